// File: rtl/cntr_pkg.sv
// Shared definitions for the up/down/load counter: the FSM state width and
// the six legal state encodings. Codes 3'b110 and 3'b111 are illegal.
package cntr_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE = 3'b000;
  localparam logic [STATE_W-1:0] ST_LOAD = 3'b001;
  localparam logic [STATE_W-1:0] ST_INC  = 3'b010;
  localparam logic [STATE_W-1:0] ST_INC2 = 3'b011;
  localparam logic [STATE_W-1:0] ST_DEC  = 3'b100;
  localparam logic [STATE_W-1:0] ST_DEC2 = 3'b101;

endpackage : cntr_pkg

// File: rtl/cntr_ns_logic.sv
// Combinational next-state logic for the counter control FSM. Only called
// on enabled edges. Load wins over direction. Holding a direction alternates
// between the plain and the "2" state. Any illegal code falls back to IDLE.
module cntr_ns_logic
  import cntr_pkg::*;
(
  input  logic               load,
  input  logic               inc,
  input  logic [STATE_W-1:0] state,
  output logic [STATE_W-1:0] next_state
);

  // Next state: legal states follow load/inc; illegal states recover to IDLE.
  always_comb begin
    // NOTE: assign a default first so every path drives the output and no latch is inferred.
    next_state = ST_IDLE;
    case (state)
      ST_IDLE, ST_LOAD, ST_INC, ST_INC2, ST_DEC, ST_DEC2: begin
        if (load) begin
          next_state = ST_LOAD;
        end else if (inc) begin
          next_state = (state == ST_INC) ? ST_INC2 : ST_INC;
        end else begin
          next_state = (state == ST_DEC) ? ST_DEC2 : ST_DEC;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

endmodule : cntr_ns_logic

// File: rtl/cntr_updn_param.sv
// Parametrised up/down/load counter. It holds the FSM state and count
// registers, a WIDTH+1 adder/subtractor whose top bit flags a boundary
// crossing, the wrap/saturate mux, a one-cycle overflow pulse and
// terminal-count decodes.
module cntr_updn_param
  import cntr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               load,
  input  logic               inc,
  input  logic               sat_mode,
  input  logic [WIDTH-1:0]   d_in,
  output logic [WIDTH-1:0]   cnt,
  output logic [STATE_W-1:0] state,
  output logic               tc_max,
  output logic               tc_min,
  output logic               ovf
);

  localparam logic [WIDTH:0] STEP_EXT = (WIDTH + 1)'(STEP);

  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] next_state;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  // The carry out of sum_up and the borrow out of diff_dn are the
  // up and down boundary detects.
  logic [WIDTH:0] sum_up;
  logic [WIDTH:0] diff_dn;

  assign sum_up  = {1'b0, cnt_q} + STEP_EXT;
  assign diff_dn = {1'b0, cnt_q} - STEP_EXT;

  cntr_ns_logic u_ns (
    .load       (load),
    .inc        (inc),
    .state      (state_q),
    .next_state (next_state)
  );

  // Next count, state and ovf. The count update depends on the state being entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    if (en) begin
      state_d = next_state;
      case (next_state)
        ST_LOAD: cnt_d = d_in;
        ST_INC, ST_INC2: begin
          if (sum_up[WIDTH]) begin
            cnt_d = sat_mode ? {WIDTH{1'b1}} : sum_up[WIDTH-1:0];
            ovf_d = 1'b1;
          end else begin
            cnt_d = sum_up[WIDTH-1:0];
          end
        end
        ST_DEC, ST_DEC2: begin
          if (diff_dn[WIDTH]) begin
            cnt_d = sat_mode ? {WIDTH{1'b0}} : diff_dn[WIDTH-1:0];
            ovf_d = 1'b1;
          end else begin
            cnt_d = diff_dn[WIDTH-1:0];
          end
        end
        default: cnt_d = cnt_q;  // IDLE, entered from an illegal code: hold
      endcase
    end
  end

  // State, count and ovf registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update together from pre-edge values.
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign cnt    = cnt_q;
  assign state  = state_q;
  assign ovf    = ovf_q;
  assign tc_max = (cnt_q == {WIDTH{1'b1}});
  assign tc_min = (cnt_q == {WIDTH{1'b0}});

endmodule : cntr_updn_param

// File: tb/tb_cntr_updn_param.sv
// Self-checking bench for cntr_updn_param. An 8-bit STEP=1 instance runs a
// table of directed vectors. A 4-bit STEP=3 instance runs hand-written
// sequences for wrap and clamp with a larger step.
module tb_cntr_updn_param;
  import cntr_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  // 8-bit, STEP=1 instance
  logic       en8, load8, inc8, sat8;
  logic [7:0] d8, cnt8;
  logic [2:0] st8;
  logic       tcmax8, tcmin8, ovf8;

  // 4-bit, STEP=3 instance
  logic       en4, load4, inc4, sat4;
  logic [3:0] d4, cnt4;
  logic [2:0] st4;
  logic       tcmax4, tcmin4, ovf4;

  cntr_updn_param #(.WIDTH(8), .STEP(1)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .en(en8), .load(load8), .inc(inc8),
    .sat_mode(sat8), .d_in(d8), .cnt(cnt8), .state(st8),
    .tc_max(tcmax8), .tc_min(tcmin8), .ovf(ovf8)
  );

  cntr_updn_param #(.WIDTH(4), .STEP(3)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .en(en4), .load(load4), .inc(inc4),
    .sat_mode(sat4), .d_in(d4), .cnt(cnt4), .state(st4),
    .tc_max(tcmax4), .tc_min(tcmin4), .ovf(ovf4)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string      tag;
    logic       rst_n, en, load, inc, sat;
    logic [7:0] d;
    logic [7:0] cnt;
    logic [2:0] st;
    logic       tcmax, tcmin, ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string tag, input logic rst_n, input logic en,
                              input logic load, input logic inc, input logic sat,
                              input logic [7:0] d, input logic [7:0] cnt,
                              input logic [2:0] st, input logic ovf);
    vec_t v;
    v.tag = tag; v.rst_n = rst_n; v.en = en; v.load = load; v.inc = inc;
    v.sat = sat; v.d = d; v.cnt = cnt; v.st = st; v.ovf = ovf;
    v.tcmax = (cnt == 8'hFF);
    v.tcmin = (cnt == 8'h00);
    return v;
  endfunction

  // Apply one step to the 4-bit instance and check it one tick after the edge.
  task automatic step4(input string tag, input logic en, input logic load,
                       input logic inc, input logic sat, input logic [3:0] d,
                       input logic [3:0] ecnt, input logic [2:0] est, input logic eovf);
    en4 = en; load4 = load; inc4 = inc; sat4 = sat; d4 = d;
    @(posedge clk); #1;
    check({tag, ".cnt"},    32'(cnt4),   32'(ecnt));
    check({tag, ".state"},  32'(st4),    32'(est));
    check({tag, ".ovf"},    32'(ovf4),   32'(eovf));
    check({tag, ".tc_max"}, 32'(tcmax4), 32'(ecnt == 4'hF));
    check({tag, ".tc_min"}, 32'(tcmin4), 32'(ecnt == 4'h0));
  endtask

  initial begin
    reset_n = 1'b0;
    en8 = 0; load8 = 0; inc8 = 0; sat8 = 0; d8 = '0;
    en4 = 0; load4 = 0; inc4 = 0; sat4 = 0; d4 = '0;

    //              tag        rst en ld inc sat d      cnt    state    ovf
    // Reset, then count up
    vecs.push_back(mk("rst0",  0,  1, 1, 1,  0, 8'h55, 8'h00, ST_IDLE, 0));
    vecs.push_back(mk("rst1",  0,  0, 0, 0,  0, 8'h00, 8'h00, ST_IDLE, 0));
    vecs.push_back(mk("up1",   1,  1, 0, 1,  0, 8'h00, 8'h01, ST_INC,  0));
    vecs.push_back(mk("up2",   1,  1, 0, 1,  0, 8'h00, 8'h02, ST_INC2, 0));
    vecs.push_back(mk("up3",   1,  1, 0, 1,  0, 8'h00, 8'h03, ST_INC,  0));
    vecs.push_back(mk("up4",   1,  1, 0, 1,  0, 8'h00, 8'h04, ST_INC2, 0));
    vecs.push_back(mk("up5",   1,  1, 0, 1,  0, 8'h00, 8'h05, ST_INC,  0));
    // Load beats inc, then count down through zero with wrap
    vecs.push_back(mk("ld3",   1,  1, 1, 1,  0, 8'h03, 8'h03, ST_LOAD, 0));
    vecs.push_back(mk("dn1",   1,  1, 0, 0,  0, 8'h00, 8'h02, ST_DEC,  0));
    vecs.push_back(mk("dn2",   1,  1, 0, 0,  0, 8'h00, 8'h01, ST_DEC2, 0));
    vecs.push_back(mk("dn3",   1,  1, 0, 0,  0, 8'h00, 8'h00, ST_DEC,  0));
    vecs.push_back(mk("dnwr",  1,  1, 0, 0,  0, 8'h00, 8'hFF, ST_DEC2, 1));
    vecs.push_back(mk("dn5",   1,  1, 0, 0,  0, 8'h00, 8'hFE, ST_DEC,  0));
    // Saturate at the top, then hold with en=0 clears ovf
    vecs.push_back(mk("ldFE",  1,  1, 1, 0,  1, 8'hFE, 8'hFE, ST_LOAD, 0));
    vecs.push_back(mk("satu1", 1,  1, 0, 1,  1, 8'h00, 8'hFF, ST_INC,  0));
    vecs.push_back(mk("satu2", 1,  1, 0, 1,  1, 8'h00, 8'hFF, ST_INC2, 1));
    vecs.push_back(mk("satu3", 1,  1, 0, 1,  1, 8'h00, 8'hFF, ST_INC,  1));
    vecs.push_back(mk("hldov", 1,  0, 0, 1,  1, 8'h00, 8'hFF, ST_INC,  0));
    // Saturate at the bottom, then switch to wrap mid-count
    vecs.push_back(mk("ld01",  1,  1, 1, 0,  1, 8'h01, 8'h01, ST_LOAD, 0));
    vecs.push_back(mk("satd1", 1,  1, 0, 0,  1, 8'h00, 8'h00, ST_DEC,  0));
    vecs.push_back(mk("satd2", 1,  1, 0, 0,  1, 8'h00, 8'h00, ST_DEC2, 1));
    vecs.push_back(mk("wrapd", 1,  1, 0, 0,  0, 8'h00, 8'hFF, ST_DEC,  1));
    // Load at a limit never flags ovf
    vecs.push_back(mk("ldFF",  1,  1, 1, 1,  1, 8'hFF, 8'hFF, ST_LOAD, 0));
    vecs.push_back(mk("ld00",  1,  1, 1, 0,  1, 8'h00, 8'h00, ST_LOAD, 0));
    // Enable hold while load/inc toggle
    vecs.push_back(mk("ld09",  1,  1, 1, 1,  0, 8'h09, 8'h09, ST_LOAD, 0));
    vecs.push_back(mk("to10",  1,  1, 0, 1,  0, 8'h00, 8'h0A, ST_INC,  0));
    vecs.push_back(mk("hold1", 1,  0, 1, 0,  0, 8'h55, 8'h0A, ST_INC,  0));
    vecs.push_back(mk("hold2", 1,  0, 0, 1,  0, 8'h55, 8'h0A, ST_INC,  0));
    vecs.push_back(mk("hold3", 1,  0, 1, 1,  0, 8'hAA, 8'h0A, ST_INC,  0));
    vecs.push_back(mk("resum", 1,  1, 0, 1,  0, 8'h00, 8'h0B, ST_INC2, 0));
    // Reset mid-operation from DEC2 ignores a pending load
    vecs.push_back(mk("ld42",  1,  1, 1, 0,  0, 8'h42, 8'h42, ST_LOAD, 0));
    vecs.push_back(mk("d41",   1,  1, 0, 0,  0, 8'h00, 8'h41, ST_DEC,  0));
    vecs.push_back(mk("d40",   1,  1, 0, 0,  0, 8'h00, 8'h40, ST_DEC2, 0));
    vecs.push_back(mk("rstmd", 0,  1, 1, 0,  0, 8'h77, 8'h00, ST_IDLE, 0));
    // Underflow right after reset, then reset clears a pending ovf
    vecs.push_back(mk("pwrap", 1,  1, 0, 0,  0, 8'h00, 8'hFF, ST_DEC,  1));
    vecs.push_back(mk("rstov", 0,  1, 0, 0,  0, 8'h00, 8'h00, ST_IDLE, 0));

    @(negedge clk);
    foreach (vecs[i]) begin
      reset_n = vecs[i].rst_n;
      en8 = vecs[i].en; load8 = vecs[i].load; inc8 = vecs[i].inc;
      sat8 = vecs[i].sat; d8 = vecs[i].d;
      @(posedge clk); #1;
      check({vecs[i].tag, ".cnt"},    32'(cnt8),   32'(vecs[i].cnt));
      check({vecs[i].tag, ".state"},  32'(st8),    32'(vecs[i].st));
      check({vecs[i].tag, ".ovf"},    32'(ovf8),   32'(vecs[i].ovf));
      check({vecs[i].tag, ".tc_max"}, 32'(tcmax8), 32'(vecs[i].tcmax));
      check({vecs[i].tag, ".tc_min"}, 32'(tcmin8), 32'(vecs[i].tcmin));
    end

    // 4-bit, STEP=3: wrap up, clamp up, and wrap down
    reset_n = 1'b1;
    en8 = 1'b0;
    step4("w4ld14", 1, 1, 1, 0, 4'd14, 4'd14, ST_LOAD, 0);
    step4("w4up1",  1, 0, 1, 0, 4'd0,  4'd1,  ST_INC,  1);
    step4("w4up2",  1, 0, 1, 0, 4'd0,  4'd4,  ST_INC2, 0);
    step4("s4ld14", 1, 1, 0, 1, 4'd14, 4'd14, ST_LOAD, 0);
    step4("s4up",   1, 0, 1, 1, 4'd0,  4'd15, ST_INC,  1);
    step4("l4ld12", 1, 1, 0, 0, 4'd12, 4'd12, ST_LOAD, 0);
    step4("l4up",   1, 0, 1, 0, 4'd0,  4'd15, ST_INC,  0);
    step4("d4ld2",  1, 1, 0, 0, 4'd2,  4'd2,  ST_LOAD, 0);
    step4("d4dn",   1, 0, 0, 0, 4'd0,  4'd15, ST_DEC,  1);
    step4("d4dn2",  1, 0, 0, 0, 4'd0,  4'd12, ST_DEC2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_cntr_updn_param
